// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run-control sequencer.
package run_ctrl_pkg;

    // Sequencer state as seen on the hex display
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    // Reason the core last entered HALT
    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_USER       = 2'd1,
        CAUSE_BREAKPOINT = 2'd2,
        CAUSE_EBREAK     = 2'd3
    } cause_t;

    localparam int unsigned   STATE_W     = 2;
    localparam logic [31:0]   EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/run_controller_btn_edge.sv
// Registered rising-edge detector for one synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    // Remember last level and flag a 0->1 transition one cycle later
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_level;
            r_rise <= i_level & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/run_controller.sv
// Run/halt/step/breakpoint sequencer producing the core clock-enable.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          AUTO_RUN = 1'b0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run_btn,
    input  logic            step_btn,
    input  logic            halt_btn,
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_addr,
    input  logic [XLEN-1:0] pc_current,
    input  logic [XLEN-1:0] instruction,
    output logic            cpu_en,
    output run_state_t      state,
    output cause_t          halt_cause,
    output logic [XLEN-1:0] retired_count
);

    logic w_run_e;
    logic w_step_e;
    logic w_halt_e;

    btn_edge u_run_edge  (.clk(clk), .resetn(resetn), .i_level(run_btn),  .o_rise(w_run_e));
    btn_edge u_step_edge (.clk(clk), .resetn(resetn), .i_level(step_btn), .o_rise(w_step_e));
    btn_edge u_halt_edge (.clk(clk), .resetn(resetn), .i_level(halt_btn), .o_rise(w_halt_e));

    run_state_t      r_state;
    cause_t          r_cause;
    logic [XLEN-1:0] r_retired_count;
    logic            r_skip;

    run_state_t      w_state_nxt;
    cause_t          w_cause_nxt;
    logic            w_cpu_en;
    logic            w_leave_halt;
    logic            w_ebreak;
    logic            w_bp_hit;
    logic            w_brk;

    // Break detection; skip masks the instruction that caused the last halt
    assign w_ebreak = (instruction == XLEN'(EBREAK_INSN));
    assign w_bp_hit = bp_en && (pc_current == bp_addr);
    assign w_brk    = !r_skip && (w_bp_hit || w_ebreak);

    // Next-state, cause and clock-enable decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cause_nxt  = r_cause;
        w_cpu_en     = 1'b0;
        w_leave_halt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (AUTO_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (w_halt_e) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_USER;
                end else if (w_step_e) begin
                    w_state_nxt = ST_STEP;
                end else if (w_run_e) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cpu_en = !w_brk && !w_halt_e;
                if (w_brk) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = w_ebreak ? CAUSE_EBREAK : CAUSE_BREAKPOINT;
                end else if (w_halt_e) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_USER;
                end
            end
            ST_STEP: begin
                w_cpu_en    = 1'b1;
                w_state_nxt = ST_HALT;
                w_cause_nxt = CAUSE_USER;
            end
            ST_HALT: begin
                if (w_halt_e) begin
                    w_cause_nxt = CAUSE_USER;
                end else if (w_step_e) begin
                    w_state_nxt  = ST_STEP;
                    w_cause_nxt  = CAUSE_NONE;
                    w_leave_halt = 1'b1;
                end else if (w_run_e) begin
                    w_state_nxt  = ST_RUN;
                    w_cause_nxt  = CAUSE_NONE;
                    w_leave_halt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    // FSM state and halt cause registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Retired counter (wrapping) and resume-skip flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_retired_count <= '0;
            r_skip          <= 1'b0;
        end else begin
            if (w_cpu_en) begin
                r_retired_count <= r_retired_count + XLEN'(1);
            end
            if (w_leave_halt) begin
                r_skip <= 1'b1;
            end else if (w_cpu_en) begin
                r_skip <= 1'b0;
            end
        end
    end

    assign cpu_en        = w_cpu_en;
    assign state         = r_state;
    assign halt_cause    = r_cause;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: driver pushes model expectations, monitor compares.
module tb_run_controller;

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc_current = '0, instruction = NOP;
    logic        cpu_en;
    logic [1:0]  state, halt_cause;
    logic [31:0] retired_count;

    run_controller dut (
        .clk(clk), .resetn(resetn), .run_btn(run_btn), .step_btn(step_btn),
        .halt_btn(halt_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc_current(pc_current),
        .instruction(instruction), .cpu_en(cpu_en), .state(state),
        .halt_cause(halt_cause), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  st;
        logic [1:0]  cs;
        logic [31:0] cnt;
        logic        en;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_id  = 0;

    // Reference model: behaviour described by the sequencer rules
    int          m_state = M_IDLE;
    int          m_cause = 0;
    logic [31:0] m_count = '0;
    bit          m_skip  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_last_r = 0, m_last_s = 0, m_last_h = 0;
    bit          m_cmd_r = 0, m_cmd_s = 0, m_cmd_h = 0;

    function automatic bit is_break();
        return !m_skip && ((bp_en && pc_current == bp_addr) || instruction == EBRK);
    endfunction

    function automatic bit exp_en();
        if (m_state == M_RUN)  return !is_break() && !m_cmd_h;
        if (m_state == M_STEP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit en;
        bit brk;
        en  = exp_en();
        brk = is_break();
        if (!resetn) begin
            m_state = M_IDLE; m_cause = 0; m_count = '0; m_skip = 0;
            m_last_r = 0; m_last_s = 0; m_last_h = 0;
            m_cmd_r = 0; m_cmd_s = 0; m_cmd_h = 0;
            m_valid = 1;
            return;
        end
        m_count = m_count + 32'(en);
        if (en) m_skip = 0;
        case (m_state)
            M_IDLE: begin
                if (m_cmd_h)      begin m_state = M_HALT; m_cause = 1; end
                else if (m_cmd_s) m_state = M_STEP;
                else if (m_cmd_r) m_state = M_RUN;
            end
            M_RUN: begin
                if (brk) begin
                    m_state = M_HALT;
                    m_cause = (instruction == EBRK) ? 3 : 2;
                end else if (m_cmd_h) begin
                    m_state = M_HALT; m_cause = 1;
                end
            end
            M_STEP: begin m_state = M_HALT; m_cause = 1; end
            default: begin
                if (m_cmd_h) m_cause = 1;
                else if (m_cmd_s) begin m_state = M_STEP; m_cause = 0; m_skip = 1; end
                else if (m_cmd_r) begin m_state = M_RUN;  m_cause = 0; m_skip = 1; end
            end
        endcase
        m_cmd_r = run_btn  && !m_last_r; m_last_r = run_btn;
        m_cmd_s = step_btn && !m_last_s; m_last_s = step_btn;
        m_cmd_h = halt_btn && !m_last_h; m_last_h = halt_btn;
    endtask

    // Drive one cycle of inputs, queue the expected view of this cycle, then advance the model
    task automatic tick(input logic rn, input logic r, input logic s, input logic h,
                        input logic [31:0] pc, input logic [31:0] ins);
        resetn = rn; run_btn = r; step_btn = s; halt_btn = h;
        pc_current = pc; instruction = ins;
        if (m_valid)
            q.push_back('{id: 16'(cyc_id), st: 2'(m_state), cs: 2'(m_cause),
                          cnt: m_count, en: exp_en()});
        cyc_id++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_n(input int n, input logic [31:0] pc, input logic [31:0] ins);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, pc, ins);
    endtask

    task automatic check(input string name, input int id, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, id, got, want);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("state",  int'(e.id), 32'(state),         32'(e.st));
            check("cause",  int'(e.id), 32'(halt_cause),    32'(e.cs));
            check("count",  int'(e.id), retired_count,      e.cnt);
            check("cpu_en", int'(e.id), 32'(cpu_en),        32'(e.en));
        end
    end

    initial begin
        // Reset held three cycles
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0, NOP);
        idle_n(2, 32'h0, NOP);

        // Run pulse, then breakpoint at 0x10
        bp_en = 1; bp_addr = 32'h10;
        tick(1, 1, 0, 0, 32'h0, NOP);
        tick(1, 0, 0, 0, 32'h0, NOP);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 32'(i * 4), NOP);
        idle_n(3, 32'h10, NOP);
        // Resume steps past the breakpoint
        tick(1, 1, 0, 0, 32'h10, NOP);
        tick(1, 0, 0, 0, 32'h10, NOP);
        tick(1, 0, 0, 0, 32'h10, NOP);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 32'h14 + 32'(i * 4), NOP);
        bp_en = 0;

        // EBREAK halt, then single step
        tick(1, 0, 0, 0, 32'h24, EBRK);
        idle_n(2, 32'h24, EBRK);
        tick(1, 0, 1, 0, 32'h24, EBRK);
        idle_n(4, 32'h24, EBRK);

        // Halt and step rise together in HALT
        tick(1, 0, 1, 1, 32'h28, NOP);
        tick(1, 0, 0, 0, 32'h28, NOP);
        idle_n(3, 32'h28, NOP);

        // Step held for 20 cycles gives one instruction
        for (int i = 0; i < 20; i++) tick(1, 0, 1, 0, 32'h28, NOP);
        idle_n(3, 32'h28, NOP);

        // Counter wrap in RUN
        tick(1, 1, 0, 0, 32'h2C, NOP);
        tick(1, 0, 0, 0, 32'h2C, NOP);
        force dut.r_retired_count = 32'hFFFF_FFFF;
        release dut.r_retired_count;
        m_count = 32'hFFFF_FFFF;
        tick(1, 0, 0, 0, 32'h2C, NOP);
        idle_n(2, 32'h30, NOP);

        // Halt, step, reset during STEP
        tick(1, 0, 0, 1, 32'h34, NOP);
        idle_n(2, 32'h34, NOP);
        tick(1, 0, 1, 0, 32'h34, NOP);
        tick(1, 0, 0, 0, 32'h34, NOP);
        tick(0, 0, 0, 0, 32'h34, NOP);
        idle_n(3, 32'h0, NOP);

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            logic        rn;
            logic [31:0] pc;
            logic [31:0] ins;
            if ($urandom_range(0, 15) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 31) == 0) bp_addr = 32'($urandom_range(0, 7)) << 2;
            rn  = ($urandom_range(0, 199) != 0);
            pc  = 32'($urandom_range(0, 7)) << 2;
            ins = ($urandom_range(0, 19) == 0) ? EBRK : ($urandom() | 32'h0000_0003) & ~32'h0000_0070;
            tick(rn,
                 ($urandom_range(0, 7) == 0) ? ~run_btn  : run_btn,
                 ($urandom_range(0, 9) == 0) ? ~step_btn : step_btn,
                 ($urandom_range(0, 23) == 0) ? ~halt_btn : halt_btn,
                 pc, ins);
        end

        idle_n(1, 32'h0, NOP);
        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
